// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the ASCII command encoder/decoder pair.
//   - 2-bit command codes and the prefix character each one is sent as
//   - encoder state enum
//   - helpers: command -> prefix byte, index of the highest nonzero nibble
package uart_cmd_pkg;

    localparam logic [1:0] CMD_READ    = 2'b00;
    localparam logic [1:0] CMD_WRITE   = 2'b01;
    localparam logic [1:0] CMD_ADDR    = 2'b10;
    localparam logic [1:0] CMD_SPECIAL = 2'b11;

    localparam logic [7:0] CHR_READ    = 8'h52; // 'R'
    localparam logic [7:0] CHR_WRITE   = 8'h57; // 'W'
    localparam logic [7:0] CHR_ADDR    = 8'h41; // 'A'
    localparam logic [7:0] CHR_SPECIAL = 8'h53; // 'S'

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PREFIX = 2'd1,
        ST_DIGIT  = 2'd2,
        ST_TERM   = 2'd3
    } enc_state_t;

    function automatic logic [7:0] cmd_prefix(input logic [1:0] cmd);
        logic [7:0] chr;
        case (cmd)
            CMD_READ:    chr = CHR_READ;
            CMD_WRITE:   chr = CHR_WRITE;
            CMD_ADDR:    chr = CHR_ADDR;
            CMD_SPECIAL: chr = CHR_SPECIAL;
            default:     chr = CHR_READ;
        endcase
        return chr;
    endfunction

    // Index (7..0) of the most significant nonzero nibble; 0 for an all-zero
    // word, so a zero value still sends one digit.
    function automatic logic [2:0] top_nz_nibble(input logic [31:0] data);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (data[4*i +: 4] != 4'h0) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/uart_encoder_if.sv
// Handshake bundle of the word encoder.
//   bus side : i_stb / i_word (34b: [33:32] command, [31:0] data) / o_busy
//   tx side  : o_tx_stb / o_tx_data (ASCII byte) / i_tx_busy (back-pressure)
// Signal names are seen from the encoder; "slave" is the encoder's view,
// "master" is the view of whoever drives words and sinks bytes.
interface uart_encoder_if;
    logic        i_stb;
    logic [33:0] i_word;
    logic        o_busy;
    logic        o_tx_stb;
    logic [7:0]  o_tx_data;
    logic        i_tx_busy;

    modport slave (
        input  i_stb, i_word, i_tx_busy,
        output o_busy, o_tx_stb, o_tx_data
    );

    modport master (
        output i_stb, i_word, i_tx_busy,
        input  o_busy, o_tx_stb, o_tx_data
    );
endinterface

// File: rtl/nibble_to_ascii.sv
// Combinational hex digit encoder: 0-9 -> '0'-'9', a-f -> lowercase 'a'-'f'.
//   i_nibble : 4-bit value
//   o_ascii  : ASCII character
module nibble_to_ascii (
    input  logic [3:0] i_nibble,
    output logic [7:0] o_ascii
);
    always_comb begin
        o_ascii = 8'h30 + {4'h0, i_nibble};
        if (i_nibble > 4'd9) o_ascii = 8'h57 + {4'h0, i_nibble}; // 8'h57 + 10 = 'a'
    end
endmodule

// File: rtl/uart_encoder.sv
// Serialises a 34-bit command word into ASCII bytes for a UART transmitter:
// prefix letter, hex digits of the data (MS nibble first), terminator.
//   i_clk, i_reset : rising-edge clock, synchronous active-high reset
//   bus (slave)    : word request (i_stb/i_word/o_busy) and byte stream
//                    (o_tx_stb/o_tx_data/i_tx_busy)
// All outputs are registered; the byte after an accepted one is computed
// combinationally so bytes can leave on consecutive cycles.
module uart_encoder
    import uart_cmd_pkg::*;
#(
    parameter logic [7:0] TERM_CHAR      = 8'h0A,
    parameter bit         SUPPRESS_ZEROS = 1'b0
) (
    input  logic          i_clk,
    input  logic          i_reset,
    uart_encoder_if.slave bus
);

    enc_state_t  state_q;
    logic [31:0] data_q;     // the command bits go straight into the prefix byte
    logic [2:0]  cnt_q;      // index of the nibble still to be presented
    logic        busy_q;
    logic        tx_stb_q;
    logic [7:0]  tx_data_q;

    logic        accept;
    logic        tx_ack;
    logic [2:0]  load_cnt;
    logic [2:0]  nib_idx;
    logic [7:0]  nib_ascii;

    assign accept   = bus.i_stb & ~busy_q;
    assign tx_ack   = tx_stb_q & ~bus.i_tx_busy;
    assign load_cnt = SUPPRESS_ZEROS ? top_nz_nibble(bus.i_word[31:0]) : 3'd7;

    // In PREFIX the next byte is nibble cnt_q; in DIGIT the byte on the wire
    // is nibble cnt_q, so the one to load next is cnt_q-1.
    assign nib_idx = (state_q == ST_DIGIT) ? cnt_q - 3'd1 : cnt_q;

    nibble_to_ascii u_n2a (
        .i_nibble (data_q[{nib_idx, 2'b00} +: 4]),
        .o_ascii  (nib_ascii)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= ST_IDLE;
            data_q    <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            tx_stb_q  <= 1'b0;
            tx_data_q <= 8'h00;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        data_q    <= bus.i_word[31:0];
                        cnt_q     <= load_cnt;
                        busy_q    <= 1'b1;
                        tx_stb_q  <= 1'b1;
                        tx_data_q <= cmd_prefix(bus.i_word[33:32]);
                        state_q   <= ST_PREFIX;
                    end
                end
                ST_PREFIX: begin
                    if (tx_ack) begin
                        tx_data_q <= nib_ascii;
                        state_q   <= ST_DIGIT;
                    end
                end
                ST_DIGIT: begin
                    if (tx_ack) begin
                        if (cnt_q == 3'd0) begin
                            tx_data_q <= TERM_CHAR;
                            state_q   <= ST_TERM;
                        end else begin
                            cnt_q     <= cnt_q - 3'd1;
                            tx_data_q <= nib_ascii;
                        end
                    end
                end
                ST_TERM: begin
                    if (tx_ack) begin
                        busy_q    <= 1'b0;
                        tx_stb_q  <= 1'b0;
                        tx_data_q <= 8'h00;
                        state_q   <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.o_busy    = busy_q;
    assign bus.o_tx_stb  = tx_stb_q;
    assign bus.o_tx_data = tx_data_q;

endmodule

// File: tb/tb_uart_encoder.sv
// Directed + random bench for uart_encoder. dut0 sends every digit, dut1
// suppresses leading zeros. Expected byte streams come from a string-based
// model (hex formatting of the data); the round trip uses a small decoder.
module tb_uart_encoder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    uart_encoder_if ifa ();
    uart_encoder_if ifb ();

    logic [1:0]       stb_a  = '0;
    logic [1:0]       txb_a  = '0;
    logic [1:0][33:0] word_a = '0;
    logic [1:0]       busy_a, tstb_a;
    logic [1:0][7:0]  tdat_a;

    assign ifa.i_stb = stb_a[0];  assign ifa.i_word = word_a[0];  assign ifa.i_tx_busy = txb_a[0];
    assign ifb.i_stb = stb_a[1];  assign ifb.i_word = word_a[1];  assign ifb.i_tx_busy = txb_a[1];
    assign busy_a[0] = ifa.o_busy;  assign tstb_a[0] = ifa.o_tx_stb;  assign tdat_a[0] = ifa.o_tx_data;
    assign busy_a[1] = ifb.o_busy;  assign tstb_a[1] = ifb.o_tx_stb;  assign tdat_a[1] = ifb.o_tx_data;

    uart_encoder #(.TERM_CHAR(8'h0A), .SUPPRESS_ZEROS(1'b0)) u_dut0 (
        .i_clk(clk), .i_reset(rst), .bus(ifa));
    uart_encoder #(.TERM_CHAR(8'h0A), .SUPPRESS_ZEROS(1'b1)) u_dut1 (
        .i_clk(clk), .i_reset(rst), .bus(ifb));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected stream: prefix letter, 8 lowercase hex digits (leading zeros
    // stripped when suppressing, one kept), then the terminator.
    function automatic void model_bytes(input logic [33:0] w, input bit sup,
                                        output logic [7:0] q[$]);
        string pre;
        string hx;
        int    s;
        pre = "RWAS";
        q = {};
        q.push_back(pre[int'(w[33:32])]);
        hx = $sformatf("%08h", w[31:0]);
        s = 0;
        if (sup) while (s < 7 && hx[s] == 8'h30) s++;
        for (int i = s; i < 8; i++) q.push_back(hx[i]);
        q.push_back(8'h0A);
    endfunction

    // Reference ASCII decoder: prefix letter -> command, hex digits -> data.
    function automatic logic [33:0] decode(input logic [7:0] q[$]);
        logic [1:0]  cmd;
        logic [31:0] data;
        logic [7:0]  c;
        logic [7:0]  v;
        case (q[0])
            8'h52:   cmd = 2'b00;
            8'h57:   cmd = 2'b01;
            8'h41:   cmd = 2'b10;
            8'h53:   cmd = 2'b11;
            default: cmd = 2'bxx;
        endcase
        data = '0;
        for (int i = 1; i < q.size() - 1; i++) begin
            c = q[i];
            v = (c >= 8'h61) ? c - 8'h57 : c - 8'h30;
            data = {data[27:0], v[3:0]};
        end
        return {cmd, data};
    endfunction

    task automatic cmp_q(input string tag, input logic [7:0] got[$], input logic [7:0] exp[$]);
        chk({tag, "_len"}, 64'(got.size()), 64'(exp.size()));
        for (int i = 0; i < got.size() && i < exp.size(); i++)
            chk($sformatf("%s_b%0d", tag, i), got[i], exp[i]);
    endtask

    // Called at a negedge with the encoder idle; returns at the negedge
    // where the first byte should be presented.
    task automatic accept_word(input int d, input logic [33:0] w);
        chk("idle_before_accept", busy_a[d], 1'b0);
        stb_a[d]  = 1'b1;
        word_a[d] = w;
        @(negedge clk);
        stb_a[d] = 1'b0;
        chk("first_byte_latency", tstb_a[d], 1'b1);
        chk("busy_after_accept", busy_a[d], 1'b1);
    endtask

    // bp: 0 always ready, 1 busy toggling 1,0,..., 2 random.
    // rej_at: cycle on which a second word request is raised (-1 none).
    task automatic collect(input int d, input int bp, input int rej_at,
                           output logic [7:0] q[$], output int ncyc);
        logic       held, txb;
        logic [7:0] hd;
        bit         done;
        q = {}; held = 1'b0; hd = 8'h00; done = 1'b0; ncyc = 0;
        while (!done && ncyc < 200) begin
            if (held) begin
                chk("hold_stb", tstb_a[d], 1'b1);
                chk("hold_data", tdat_a[d], hd);
            end
            case (bp)
                0:       txb = 1'b0;
                1:       txb = (ncyc % 2 == 0);
                default: txb = 1'($urandom_range(0, 1));
            endcase
            txb_a[d] = txb;
            if (ncyc == rej_at) begin
                stb_a[d]  = 1'b1;
                word_a[d] = {2'b00, 32'h12345678};
            end else begin
                stb_a[d] = 1'b0;
            end
            if (tstb_a[d] && !txb) begin
                q.push_back(tdat_a[d]);
                held = 1'b0;
                if (tdat_a[d] == 8'h0A) done = 1'b1;
            end else begin
                held = tstb_a[d];
                hd   = tdat_a[d];
            end
            @(negedge clk);
            ncyc++;
        end
        txb_a[d] = 1'b0;
        stb_a[d] = 1'b0;
        if (!done) chk("collect_timeout", 1'b0, 1'b1);
        chk("busy_after_term", busy_a[d], 1'b0);
        chk("stb_after_term", tstb_a[d], 1'b0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  got[$];
        logic [7:0]  exp[$];
        logic [33:0] w;
        logic [1:0]  rc;
        logic [31:0] rd;
        int          n, c0;

        // reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_busy", busy_a[d], 1'b0);
            chk("rst_stb", tstb_a[d], 1'b0);
            chk("rst_data", tdat_a[d], 8'h00);
        end
        rst = 1'b0;
        @(negedge clk);

        // single word, ready transmitter: 10 bytes on 10 consecutive cycles
        w = {2'b01, 32'hDEADBEEF};
        accept_word(0, w);
        collect(0, 0, -1, got, n);
        model_bytes(w, 1'b0, exp);
        cmp_q("deadbeef", got, exp);
        chk("deadbeef_cycles", 64'(n), 64'd10);
        chk("deadbeef_b1_literal", got[1], 8'h64);

        // toggling back-pressure
        w = {2'b00, 32'h0000001F};
        accept_word(0, w);
        collect(0, 1, -1, got, n);
        model_bytes(w, 1'b0, exp);
        cmp_q("bp_1f", got, exp);

        // zero suppression
        w = {2'b10, 32'h00000000};
        accept_word(1, w);
        collect(1, 0, -1, got, n);
        model_bytes(w, 1'b1, exp);
        cmp_q("sup_zero", got, exp);
        chk("sup_zero_len_literal", 64'(got.size()), 64'd3);
        w = {2'b11, 32'h00A00000};
        accept_word(1, w);
        collect(1, 2, -1, got, n);
        model_bytes(w, 1'b1, exp);
        cmp_q("sup_a0", got, exp);

        // second request while busy is dropped
        w = {2'b01, 32'hCAFE0123};
        accept_word(0, w);
        collect(0, 0, 2, got, n);
        model_bytes(w, 1'b0, exp);
        cmp_q("busy_reject", got, exp);
        repeat (3) begin
            chk("reject_no_stb", tstb_a[0], 1'b0);
            chk("reject_no_busy", busy_a[0], 1'b0);
            @(negedge clk);
        end

        // reset while the 4th byte is on the wire
        w = {2'b10, 32'h89ABCDEF};
        model_bytes(w, 1'b0, exp);
        accept_word(0, w);
        repeat (3) @(negedge clk);
        chk("midrst_b3_before", tdat_a[0], exp[3]);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_stb", tstb_a[0], 1'b0);
        chk("midrst_busy", busy_a[0], 1'b0);
        chk("midrst_data", tdat_a[0], 8'h00);
        w = {2'b11, 32'h0F1E2D3C};
        accept_word(0, w);
        collect(0, 0, -1, got, n);
        model_bytes(w, 1'b0, exp);
        cmp_q("after_rst", got, exp);

        // throughput: back-to-back words, one per 11 cycles
        c0 = cyc;
        for (int k = 0; k < 3; k++) begin
            w = {2'(k), 32'h11111111 * (k + 1)};
            accept_word(0, w);
            collect(0, 0, -1, got, n);
            model_bytes(w, 1'b0, exp);
            cmp_q($sformatf("b2b%0d", k), got, exp);
        end
        chk("b2b_cycles", 64'(cyc - c0), 64'd33);

        // random round trip, full-width encoder
        for (int k = 0; k < 1000; k++) begin
            rc = 2'($urandom_range(0, 3));
            rd = $urandom;
            w  = {rc, rd};
            accept_word(0, w);
            collect(0, $urandom_range(0, 2), -1, got, n);
            model_bytes(w, 1'b0, exp);
            chk("rt_len", 64'(got.size()), 64'(exp.size()));
            chk("rt_word", decode(got), w);
        end

        // random round trip with suppression, sparse data
        for (int k = 0; k < 300; k++) begin
            rc = 2'($urandom_range(0, 3));
            rd = $urandom >> $urandom_range(0, 32);
            w  = {rc, rd};
            accept_word(1, w);
            collect(1, $urandom_range(0, 2), -1, got, n);
            model_bytes(w, 1'b1, exp);
            cmp_q("rt_sup", got, exp);
            chk("rt_sup_word", decode(got), w);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_encoder.md
UART_ENCODER -- requirements
Module: uart_encoder

Interface
REQ-001 Parameter TERM_CHAR, default 8'h0A, is the terminator byte appended after every word.
REQ-002 Parameter SUPPRESS_ZEROS, default 0; when 1, leading zero hex digits are dropped, with at least one digit always kept.
REQ-003 i_clk  input  1  sole clock; all logic is rising-edge.
REQ-004 i_reset  input  1  reset, synchronous and active-high.
REQ-005 i_stb  input  1  word request from the bus side.
REQ-006 i_word  input  34  word to send: [33:32] command code, [31:0] data.
REQ-007 o_busy  output  1  high while a word is held or being emitted.
REQ-008 o_tx_stb  output  1  byte valid towards the UART transmitter.
REQ-009 o_tx_data  output  8  ASCII byte towards the UART transmitter.
REQ-010 i_tx_busy  input  1  high means the transmitter cannot accept a byte this cycle.

Function
REQ-011 Word acceptance: a word is accepted on a cycle with i_stb=1 and o_busy=0; i_word is captured into an internal register on that edge.
REQ-012 Ignored requests: i_stb while o_busy=1 is ignored, with no queueing.
REQ-013 o_busy timing: o_busy rises on the edge after acceptance and falls on the edge after the terminator is accepted.
REQ-014 Byte handshake: a byte is accepted by the transmitter on any cycle with o_tx_stb=1 and i_tx_busy=0.
REQ-015 Byte hold: o_tx_stb and o_tx_data hold stable until that byte is accepted.
REQ-016 Command prefix: [33:32] maps 00->'R'(8'h52), 01->'W'(8'h57), 10->'A'(8'h41), 11->'S'(8'h53).
REQ-017 Digit mapping: values 0-9 map to 8'h30-8'h39; values a-f map to lowercase 8'h61-8'h66.
REQ-018 Emission order: prefix, then the data nibbles most-significant first ([31:28] down to [3:0]), then TERM_CHAR.
REQ-019 Byte count: with SUPPRESS_ZEROS=0 every word produces exactly 10 bytes.
REQ-020 Zero suppression: with SUPPRESS_ZEROS=1, the first digit sent is the highest nonzero nibble; data 0 sends the single digit '0'.
REQ-021 State machine: IDLE, PREFIX, DIGIT, TERM.
- IDLE->PREFIX on word acceptance.
- PREFIX->DIGIT on byte acceptance.
- DIGIT stays until the last nibble's byte is accepted, then goes to TERM.
- TERM->IDLE on byte acceptance.
REQ-022 Nibble counter: a 3-bit down-counter, loaded with 7 (or with the highest nonzero nibble index when suppressing), decrements on each accepted digit, and exits DIGIT when it is 0.
REQ-023 First byte timing: o_tx_stb asserts on the edge after acceptance, i.e. one cycle of latency from i_stb to the first byte.
REQ-024 Back-to-back bytes: consecutive bytes may be presented on consecutive cycles when i_tx_busy stays low.
REQ-025 Throughput: a continuously ready transmitter yields one word per 11 cycles (request cycle plus 10 bytes) with SUPPRESS_ZEROS=0.
REQ-026 No mid-byte abort: i_tx_busy rising while a byte is presented does not withdraw or change that byte.

Reset
REQ-027 Synchronous reset effect: i_reset=1 at a rising edge forces state IDLE, o_busy=0, o_tx_stb=0, o_tx_data=8'h00, nibble counter 0, and captured word 0.
REQ-028 Reset mid-word: reset during a word abandons it with no terminator, and the first edge after reset release may accept a new word.
REQ-029 Priority: reset has priority over i_stb and byte acceptance in the same cycle.

Structure
REQ-030 Shared package uart_cmd_pkg holds:
- the 2-bit command code constants (CMD_READ=00, CMD_WRITE=01, CMD_ADDR=10, CMD_SPECIAL=11);
- the prefix character constants;
- the encoder state enum.
REQ-031 Sub-module nibble_to_ascii, purely combinational (4-bit in, 8-bit out), is reused by the encoder and available to the decoder side.
REQ-032 The byte stream shall round-trip through the existing ASCII decoder to the same 34-bit word.

Verification
REQ-033 Single word: i_word={2'b01,32'hDEADBEEF}, i_tx_busy=0 -> bytes 57 64 65 61 64 62 65 65 66 0A on 10 consecutive cycles; o_busy low after.
REQ-034 Backpressure: i_word={2'b00,32'h0000001F}, i_tx_busy toggling 1,0 each cycle -> bytes 52 30 30 30 30 30 30 31 66 0A with each byte held stable while busy, and no byte dropped or duplicated.
REQ-035 Zero suppression: SUPPRESS_ZEROS=1 with i_word={2'b10,32'h00000000} -> 41 30 0A; with i_word={2'b11,32'h00A00000} -> 53 61 30 30 30 30 30 0A.
REQ-036 Busy rejection: second i_stb (data 32'h12345678) three cycles after the first accepted word -> ignored; only the first word's 10 bytes appear.
REQ-037 Mid-word reset: i_reset pulsed while the 4th byte is presented -> o_tx_stb=0 and o_busy=0 on the next cycle; a new word then emits its complete 10 bytes.
REQ-038 Round trip: encoder output fed to the ASCII decoder for 1000 random words -> decoded word equals i_word each time.
